// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one block memory between icache refill and dcache refill/writeback
// Serialises misses with a busywait handshake; round-robin or dcache-first under contention.
module cache_mem_arbiter #(
    parameter int ADDR_W    = 28,
    parameter int DATA_W    = 128,
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ic_read,
    input  logic [ADDR_W-1:0] i_ic_address,
    output logic [DATA_W-1:0] o_ic_readdata,
    output logic              o_ic_busywait,
    input  logic              i_dc_read,
    input  logic              i_dc_write,
    input  logic [ADDR_W-1:0] i_dc_address,
    input  logic [DATA_W-1:0] i_dc_writedata,
    output logic [DATA_W-1:0] o_dc_readdata,
    output logic              o_dc_busywait,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [DATA_W-1:0] o_mem_writedata,
    input  logic [DATA_W-1:0] i_mem_readdata,
    input  logic              i_mem_busywait
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last_grant;
    logic              r_owner;
    logic              r_issued;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_writedata;
    logic [DATA_W-1:0] r_ic_readdata;
    logic [DATA_W-1:0] r_dc_readdata;
    logic              w_ic_req;
    logic              w_dc_req;
    logic              w_grant_d;
    logic              w_done;

    // last_grant / owner encoding: 0 = icache, 1 = dcache
    always_comb begin
        w_ic_req    = i_ic_read;
        w_dc_req    = i_dc_read | i_dc_write;
        w_grant_d   = w_dc_req & (~w_ic_req | ~RR_ENABLE | ~r_last_grant);
        w_done      = r_issued & ~i_mem_busywait;
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d)
                    w_state_nxt = SERVE_D;
                else if (w_ic_req)
                    w_state_nxt = SERVE_I;
            end
            SERVE_I, SERVE_D: begin
                if (w_done)
                    w_state_nxt = RELEASE;
            end
            RELEASE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_grant    <= 1'b0;
            r_owner         <= 1'b0;
            r_issued        <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_address   <= '0;
            r_mem_writedata <= '0;
            r_ic_readdata   <= '0;
            r_dc_readdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_state_nxt != IDLE) begin
                        r_issued     <= 1'b0;
                        r_owner      <= w_grant_d;
                        r_last_grant <= w_grant_d;
                        if (w_grant_d) begin
                            r_mem_address   <= i_dc_address;
                            r_mem_writedata <= i_dc_writedata;
                            // read and write together is resolved as a write
                            r_mem_read      <= i_dc_read & ~i_dc_write;
                            r_mem_write     <= i_dc_write;
                        end else begin
                            r_mem_address   <= i_ic_address;
                            r_mem_read      <= 1'b1;
                            r_mem_write     <= 1'b0;
                        end
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (!r_issued) begin
                        r_issued <= 1'b1;
                    end else if (w_done) begin
                        r_issued    <= 1'b0;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        if (r_state == SERVE_I)
                            r_ic_readdata <= i_mem_readdata;
                        else if (r_mem_read)
                            r_dc_readdata <= i_mem_readdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ic_busywait   = w_ic_req & ~((r_state == RELEASE) & ~r_owner);
    assign o_dc_busywait   = w_dc_req & ~((r_state == RELEASE) & r_owner);
    assign o_mem_read      = r_mem_read;
    assign o_mem_write     = r_mem_write;
    assign o_mem_address   = r_mem_address;
    assign o_mem_writedata = r_mem_writedata;
    assign o_ic_readdata   = r_ic_readdata;
    assign o_dc_readdata   = r_dc_readdata;

    a_no_read_and_write: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_dc_read && i_dc_write));

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;
    localparam logic [DW-1:0] BLK_IM = {32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'h00000001};
    localparam logic [DW-1:0] BLK_I  = {4{32'hA5A5_0001}};
    localparam logic [DW-1:0] BLK_D  = {4{32'h5A5A_0002}};
    localparam logic [DW-1:0] BLK_X  = {4{32'h5555_5555}};
    localparam logic [DW-1:0] WD1    = {4{32'h1111_1111}};
    localparam logic [DW-1:0] WD2    = {4{32'h2222_2222}};
    localparam logic [AW-1:0] A_I    = 28'h0000100;
    localparam logic [AW-1:0] A_D    = 28'h0000200;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ic_read = 1'b0, dc_read = 1'b0, dc_write = 1'b0;
    logic [AW-1:0] ic_address = '0, dc_address = '0;
    logic [DW-1:0] dc_writedata = '0, mem_readdata = '0;
    logic          mem_busywait = 1'b0;
    logic [DW-1:0] ic_readdata, dc_readdata, mem_writedata;
    logic          ic_busywait, dc_busywait, mem_read, mem_write;
    logic [AW-1:0] mem_address;

    logic          nr_ic_read = 1'b0, nr_dc_read = 1'b0;
    logic          nr_mem_busywait = 1'b0;
    logic [DW-1:0] nr_ic_readdata, nr_dc_readdata, nr_mem_writedata;
    logic          nr_ic_busywait, nr_dc_busywait, nr_mem_read, nr_mem_write;
    logic [AW-1:0] nr_mem_address;

    int n_cmp = 0;
    int n_bad = 0;
    int mem_wait = 0;
    int m_cnt = 0;
    bit m_active = 1'b0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_ENABLE(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ic_read(ic_read), .i_ic_address(ic_address),
        .o_ic_readdata(ic_readdata), .o_ic_busywait(ic_busywait),
        .i_dc_read(dc_read), .i_dc_write(dc_write), .i_dc_address(dc_address),
        .i_dc_writedata(dc_writedata), .o_dc_readdata(dc_readdata), .o_dc_busywait(dc_busywait),
        .o_mem_read(mem_read), .o_mem_write(mem_write), .o_mem_address(mem_address),
        .o_mem_writedata(mem_writedata), .i_mem_readdata(mem_readdata), .i_mem_busywait(mem_busywait)
    );

    cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_ENABLE(1'b0)) dut_nr (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ic_read(nr_ic_read), .i_ic_address(A_I),
        .o_ic_readdata(nr_ic_readdata), .o_ic_busywait(nr_ic_busywait),
        .i_dc_read(nr_dc_read), .i_dc_write(1'b0), .i_dc_address(A_D),
        .i_dc_writedata(WD1), .o_dc_readdata(nr_dc_readdata), .o_dc_busywait(nr_dc_busywait),
        .o_mem_read(nr_mem_read), .o_mem_write(nr_mem_write), .o_mem_address(nr_mem_address),
        .o_mem_writedata(nr_mem_writedata), .i_mem_readdata(BLK_D), .i_mem_busywait(nr_mem_busywait)
    );

    // memory: busy for mem_wait cycles after it first sees a strobe
    always @(posedge clk) begin
        #2;
        if (mem_read || mem_write) begin
            if (!m_active) begin
                m_active = 1'b1;
                m_cnt = mem_wait;
            end else if (m_cnt > 0) begin
                m_cnt--;
            end
        end else begin
            m_active = 1'b0;
            m_cnt = 0;
        end
        mem_busywait = (m_cnt > 0);
    end

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_free(input bit side_d, output int n, output int strobes);
        n = 0;
        strobes = 0;
        do begin
            @(negedge clk);
            n++;
            if (mem_read || mem_write) strobes++;
        end while ((side_d ? dc_busywait : ic_busywait) && n < 60);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(2);
        n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL rst_mem_read: got %b want 0", mem_read); end
        n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL rst_mem_write: got %b want 0", mem_write); end
        n_cmp++; if (mem_address !== '0) begin n_bad++; $display("FAIL rst_mem_address: got %h want 0", mem_address); end
        n_cmp++; if (mem_writedata !== '0) begin n_bad++; $display("FAIL rst_mem_writedata: got %h want 0", mem_writedata); end
        n_cmp++; if (ic_readdata !== '0) begin n_bad++; $display("FAIL rst_ic_readdata: got %h want 0", ic_readdata); end
        n_cmp++; if (dc_readdata !== '0) begin n_bad++; $display("FAIL rst_dc_readdata: got %h want 0", dc_readdata); end
        n_cmp++; if ({ic_busywait, dc_busywait} !== 2'b00) begin n_bad++; $display("FAIL rst_busywait: got %b want 00", {ic_busywait, dc_busywait}); end
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_icache_miss();
        int n, s;
        mem_wait = 5;
        mem_readdata = BLK_IM;
        ic_address = 28'h0000010;
        ic_read = 1'b1;
        n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL ic_miss_idle_read: got %b want 0", mem_read); end
        step(1);
        n_cmp++; if (mem_read !== 1'b1) begin n_bad++; $display("FAIL ic_miss_read_rise: got %b want 1", mem_read); end
        n_cmp++; if (mem_address !== 28'h0000010) begin n_bad++; $display("FAIL ic_miss_addr: got %h want 0000010", mem_address); end
        wait_free(1'b0, n, s);
        n_cmp++; if (n !== 6) begin n_bad++; $display("FAIL ic_miss_latency: got %0d want 6", n); end
        n_cmp++; if (s !== 5) begin n_bad++; $display("FAIL ic_miss_strobe_cycles: got %0d want 5", s); end
        n_cmp++; if (ic_readdata !== BLK_IM) begin n_bad++; $display("FAIL ic_miss_data: got %h want %h", ic_readdata, BLK_IM); end
        n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL ic_miss_release_read: got %b want 0", mem_read); end
        step(1);
        n_cmp++; if (ic_busywait !== 1'b1) begin n_bad++; $display("FAIL ic_miss_busy_one_cycle: got %b want 1", ic_busywait); end
        n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL ic_miss_idle_after: got %b want 0", mem_read); end
        ic_read = 1'b0;
        step(1);
        n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL ic_miss_no_regrant: got %b want 0", mem_read); end
    endtask

    task automatic test_contention();
        mem_wait = 0;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        ic_address = A_I;
        dc_address = A_D;
        mem_readdata = BLK_D;
        ic_read = 1'b1;
        dc_read = 1'b1;
        step(1);
        n_cmp++; if (mem_address !== A_D || mem_read !== 1'b1) begin n_bad++; $display("FAIL rr_first_d: got addr %h read %b want %h 1", mem_address, mem_read, A_D); end
        step(2);
        n_cmp++; if (dc_busywait !== 1'b0 || dc_readdata !== BLK_D) begin n_bad++; $display("FAIL rr_d_done: got busy %b data %h want 0 %h", dc_busywait, dc_readdata, BLK_D); end
        dc_read = 1'b0;
        mem_readdata = BLK_I;
        step(1);
        n_cmp++; if (mem_read !== 1'b0 || ic_busywait !== 1'b1) begin n_bad++; $display("FAIL rr_turnaround: got read %b ibusy %b want 0 1", mem_read, ic_busywait); end
        step(1);
        n_cmp++; if (mem_address !== A_I || mem_read !== 1'b1) begin n_bad++; $display("FAIL rr_then_i: got addr %h read %b want %h 1", mem_address, mem_read, A_I); end
        step(2);
        n_cmp++; if (ic_busywait !== 1'b0 || ic_readdata !== BLK_I) begin n_bad++; $display("FAIL rr_i_done: got busy %b data %h want 0 %h", ic_busywait, ic_readdata, BLK_I); end
        ic_read = 1'b0;
        step(1);
        mem_readdata = BLK_D;
        dc_read = 1'b1;
        step(3);
        n_cmp++; if (dc_busywait !== 1'b0) begin n_bad++; $display("FAIL rr_lone_d_done: got %b want 0", dc_busywait); end
        dc_read = 1'b0;
        step(1);
        mem_readdata = BLK_I;
        ic_read = 1'b1;
        dc_read = 1'b1;
        step(1);
        n_cmp++; if (mem_address !== A_I || mem_read !== 1'b1) begin n_bad++; $display("FAIL rr_second_i_first: got addr %h read %b want %h 1", mem_address, mem_read, A_I); end
        step(2);
        ic_read = 1'b0;
        mem_readdata = BLK_D;
        step(2);
        n_cmp++; if (mem_address !== A_D || mem_read !== 1'b1) begin n_bad++; $display("FAIL rr_second_d_next: got addr %h read %b want %h 1", mem_address, mem_read, A_D); end
        step(2);
        n_cmp++; if (dc_busywait !== 1'b0 || dc_readdata !== BLK_D) begin n_bad++; $display("FAIL rr_second_d_done: got busy %b data %h want 0 %h", dc_busywait, dc_readdata, BLK_D); end
        dc_read = 1'b0;
        step(1);
    endtask

    task automatic test_fixed_priority();
        nr_dc_read = 1'b1;
        step(1);
        n_cmp++; if (nr_mem_address !== A_D || nr_mem_read !== 1'b1) begin n_bad++; $display("FAIL fp_lone_d: got addr %h read %b want %h 1", nr_mem_address, nr_mem_read, A_D); end
        step(2);
        nr_dc_read = 1'b0;
        step(1);
        nr_ic_read = 1'b1;
        nr_dc_read = 1'b1;
        step(1);
        n_cmp++; if (nr_mem_address !== A_D || nr_mem_read !== 1'b1) begin n_bad++; $display("FAIL fp_d_wins_again: got addr %h read %b want %h 1", nr_mem_address, nr_mem_read, A_D); end
        step(2);
        n_cmp++; if (nr_dc_busywait !== 1'b0 || nr_ic_busywait !== 1'b1) begin n_bad++; $display("FAIL fp_release: got dbusy %b ibusy %b want 0 1", nr_dc_busywait, nr_ic_busywait); end
        nr_ic_read = 1'b0;
        nr_dc_read = 1'b0;
        step(2);
    endtask

    task automatic test_back_to_back();
        int last_i, first_d, busy_err;
        bit done;
        last_i = -1;
        first_d = -1;
        busy_err = 0;
        done = 1'b0;
        mem_wait = 3;
        mem_readdata = BLK_I;
        ic_address = A_I;
        dc_address = A_D;
        ic_read = 1'b1;
        for (int c = 1; c <= 60 && !done; c++) begin
            @(negedge clk);
            if (mem_read && mem_address == A_I) last_i = c;
            if (mem_read && mem_address == A_D && first_d < 0) first_d = c;
            if (ic_read && c >= 2 && !dc_busywait) busy_err++;
            if (ic_read && !ic_busywait) begin
                ic_read = 1'b0;
                mem_readdata = BLK_D;
            end
            if (dc_read && !dc_busywait) begin
                done = 1'b1;
                dc_read = 1'b0;
            end
            if (c == 1) dc_read = 1'b1;
        end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_timeout: got done %b want 1", done); end
        n_cmp++; if (last_i !== 4) begin n_bad++; $display("FAIL b2b_i_last_strobe: got %0d want 4", last_i); end
        n_cmp++; if (first_d - last_i !== 3) begin n_bad++; $display("FAIL b2b_gap: got %0d want 3", first_d - last_i); end
        n_cmp++; if (busy_err !== 0) begin n_bad++; $display("FAIL b2b_dc_busy_held: got %0d low cycles want 0", busy_err); end
        n_cmp++; if (ic_readdata !== BLK_I || dc_readdata !== BLK_D) begin n_bad++; $display("FAIL b2b_data: got %h %h want %h %h", ic_readdata, dc_readdata, BLK_I, BLK_D); end
        step(1);
    endtask

    task automatic test_writeback();
        int n, s;
        mem_wait = 2;
        mem_readdata = BLK_X;
        dc_address = 28'h0ABCDEF;
        dc_writedata = WD1;
        dc_write = 1'b1;
        step(1);
        n_cmp++; if ({mem_write, mem_read} !== 2'b10) begin n_bad++; $display("FAIL wb_strobes: got w%b r%b want w1 r0", mem_write, mem_read); end
        n_cmp++; if (mem_address !== 28'h0ABCDEF) begin n_bad++; $display("FAIL wb_addr: got %h want 0abcdef", mem_address); end
        dc_writedata = WD2;
        dc_address = 28'h1234567;
        wait_free(1'b1, n, s);
        n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL wb_latency: got %0d want 3", n); end
        n_cmp++; if (mem_writedata !== WD1 || mem_address !== 28'h0ABCDEF) begin n_bad++; $display("FAIL wb_latched: got %h @%h want %h @0abcdef", mem_writedata, mem_address, WD1); end
        n_cmp++; if (dc_readdata !== BLK_D) begin n_bad++; $display("FAIL wb_readdata_kept: got %h want %h", dc_readdata, BLK_D); end
        n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL wb_strobe_drop: got %b want 0", mem_write); end
        dc_write = 1'b0;
        step(1);
    endtask

    task automatic test_zero_wait();
        int n, s;
        mem_wait = 0;
        mem_readdata = BLK_I;
        ic_address = A_I;
        ic_read = 1'b1;
        wait_free(1'b0, n, s);
        n_cmp++; if (n !== 3 || s !== 2) begin n_bad++; $display("FAIL zw_ic_timing: got lat %0d strobes %0d want 3 2", n, s); end
        ic_read = 1'b0;
        step(1);
        mem_readdata = BLK_X;
        dc_address = A_D;
        dc_read = 1'b1;
        wait_free(1'b1, n, s);
        n_cmp++; if (n !== 3 || s !== 2) begin n_bad++; $display("FAIL zw_dc_timing: got lat %0d strobes %0d want 3 2", n, s); end
        n_cmp++; if (dc_readdata !== BLK_X) begin n_bad++; $display("FAIL zw_dc_data: got %h want %h", dc_readdata, BLK_X); end
        dc_read = 1'b0;
        step(1);
    endtask

    task automatic test_reset_mid();
        int n, s;
        mem_wait = 10;
        dc_address = A_D;
        dc_read = 1'b1;
        step(2);
        n_cmp++; if (mem_read !== 1'b1) begin n_bad++; $display("FAIL rm_serving: got %b want 1", mem_read); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL rm_async_drop: got %b want 0", mem_read); end
        dc_read = 1'b0;
        step(1);
        rst_n = 1'b1;
        mem_wait = 0;
        step(1);
        mem_readdata = BLK_I;
        ic_address = A_I;
        ic_read = 1'b1;
        step(1);
        n_cmp++; if (mem_read !== 1'b1 || mem_address !== A_I) begin n_bad++; $display("FAIL rm_fresh_grant: got read %b addr %h want 1 %h", mem_read, mem_address, A_I); end
        wait_free(1'b0, n, s);
        n_cmp++; if (n !== 2 || ic_readdata !== BLK_I) begin n_bad++; $display("FAIL rm_fresh_done: got lat %0d data %h want 2 %h", n, ic_readdata, BLK_I); end
        n_cmp++; if (dc_readdata !== '0) begin n_bad++; $display("FAIL rm_dc_readdata: got %h want 0", dc_readdata); end
        ic_read = 1'b0;
        step(1);
    endtask

    initial begin
        test_reset();
        test_icache_miss();
        test_contention();
        test_fixed_priority();
        test_back_to_back();
        test_writeback();
        test_zero_wait();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
